// File: rtl/key_event_ctrl_pkg.sv
// Shared definitions for the key event controller: FSM state
// encoding and the derived-constant helper functions.
package key_event_ctrl_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE    = 2'd0,
        KEY_PRESSED = 2'd1,
        KEY_LONG    = 2'd2
    } key_state_e;

    function automatic int f_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int f_tick_div(input int clk_hz, input int sample_ms);
        return clk_hz / 1000 * sample_ms;
    endfunction

    function automatic int f_long_ticks(input int long_ms, input int sample_ms);
        return long_ms / sample_ms;
    endfunction

    function automatic int f_repeat_ticks(input int rep_ms, input int sample_ms);
        return rep_ms / sample_ms;
    endfunction

endpackage

// File: rtl/key_event_ctrl_chan.sv
// One key channel: 2-FF synchroniser, tick-sampled debounce and the
// press/long/repeat event FSM. Repeat logic exists only with KEY_EVENT_REPEAT_EN.
module key_chan
    import key_event_ctrl_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4,
    parameter int LONG_TICKS     = 200
`ifdef KEY_EVENT_REPEAT_EN
    ,
    parameter int REPEAT_TICKS   = 40
`endif
)
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    input  logic i_tick,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int DB_W   = f_clog2(STABLE_SAMPLES + 1);
    localparam int HOLD_W = f_clog2(LONG_TICKS + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(STABLE_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_level;
    key_state_e        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_press;
    logic              r_release;
    logic              r_long;

    logic              w_press_s;
    logic [DB_W-1:0]   w_db_nxt;
    logic              w_level_nxt;
    logic              w_rise;
    logic              w_fall;
    key_state_e        w_state_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_press;
    logic              w_release;
    logic              w_long;

    assign w_press_s = ~r_sync2;

    // Bring the asynchronous pin into the clock domain; idle is released.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: count consecutive differing samples, flip level on the last.
    always_comb begin
        w_level_nxt = r_level;
        w_db_nxt    = r_db_cnt;
        if (i_tick) begin
            if (w_press_s == r_level) begin
                w_db_nxt = '0;
            end else if (r_db_cnt == DB_LAST) begin
                w_level_nxt = ~r_level;
                w_db_nxt    = '0;
            end else begin
                w_db_nxt = r_db_cnt + 1'b1;
            end
        end
    end

    assign w_rise = w_level_nxt & ~r_level;
    assign w_fall = ~w_level_nxt & r_level;

    // Debounce state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else begin
            r_db_cnt <= w_db_nxt;
            r_level  <= w_level_nxt;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    localparam int REP_W = f_clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_nxt;
    logic             r_repeat;
    logic             w_repeat;
`endif

    // Event FSM: a falling level always wins over long/repeat thresholds.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
        w_rep_nxt   = r_rep_cnt;
        w_repeat    = 1'b0;
`endif
        if (w_fall) begin
            w_state_nxt = KEY_IDLE;
            w_release   = 1'b1;
        end else begin
            unique case (r_state)
                KEY_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = KEY_PRESSED;
                        w_press     = 1'b1;
                        w_hold_nxt  = '0;
                    end
                end
                KEY_PRESSED: begin
                    if (i_tick) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            w_state_nxt = KEY_LONG;
                            w_long      = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
                            w_rep_nxt   = '0;
`endif
                        end else if (r_hold_cnt < HOLD_LAST) begin
                            w_hold_nxt = r_hold_cnt + 1'b1;
                        end
                    end
                end
                KEY_LONG: begin
`ifdef KEY_EVENT_REPEAT_EN
                    if (i_tick) begin
                        if (r_rep_cnt == REP_LAST) begin
                            w_repeat  = 1'b1;
                            w_rep_nxt = '0;
                        end else begin
                            w_rep_nxt = r_rep_cnt + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    w_state_nxt = KEY_IDLE;
                end
            endcase
        end
    end

    // Event state, hold counter and registered single-cycle pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= KEY_IDLE;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_press    <= w_press;
            r_release  <= w_release;
            r_long     <= w_long;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    // Auto-repeat period counter and pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rep_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_rep_cnt <= w_rep_nxt;
            r_repeat  <= w_repeat;
        end
    end

    assign o_repeat = r_repeat;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/key_event_ctrl.sv
// Multi-key front end: shared sample-tick prescaler feeding NUM_KEYS
// key_chan instances. Optional auto-repeat via KEY_EVENT_REPEAT_EN.
module key_event_ctrl
    import key_event_ctrl_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int CLK_HZ         = 50000000,
    parameter int SAMPLE_MS      = 5,
    parameter int STABLE_SAMPLES = 4,
    parameter int LONG_MS        = 1000,
    parameter int REPEAT_MS      = 200
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    localparam int TICK_DIV   = f_tick_div(CLK_HZ, SAMPLE_MS);
    localparam int TD_W       = f_clog2(TICK_DIV);
    localparam int LONG_TICKS = f_long_ticks(LONG_MS, SAMPLE_MS);
    localparam logic [TD_W-1:0] TD_LAST = TD_W'(TICK_DIV - 1);
`ifdef KEY_EVENT_REPEAT_EN
    localparam int REPEAT_TICKS = f_repeat_ticks(REPEAT_MS, SAMPLE_MS);
`endif

    logic [TD_W-1:0] r_presc;
    logic            w_tick;

    assign w_tick = (r_presc == TD_LAST);

    // Shared prescaler: 0..TICK_DIV-1, tick on the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_chan #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .LONG_TICKS     (LONG_TICKS)
`ifdef KEY_EVENT_REPEAT_EN
            ,
            .REPEAT_TICKS   (REPEAT_TICKS)
`endif
        ) u_chan (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_key_n   (key_n[g]),
            .i_tick    (w_tick),
            .o_level   (key_level[g]),
            .o_press   (press_pulse[g]),
            .o_release (release_pulse[g]),
            .o_long    (long_pulse[g]),
            .o_repeat  (repeat_pulse[g])
        );
    end

endmodule
